grid_scan_addr_gen: RTL and testbench

//  Consumes the packed 14-bit size string ([6:0]=sizeX, [13:7]=sizeY) and walks every cell of the

---
 rtl/grid_scan_addr_gen.sv | 126 ++++++++++++
 tb/tb_grid_scan_addr_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_scan_addr_gen.sv
// Row-major grid walker: emits (x, y, y*sizeX+x) for every cell of a latched sizeX x sizeY grid
// over a valid/ready stream, then pulses done.
module grid_scan_addr_gen #(
    parameter int unsigned COORD_W = 7,
    parameter int unsigned ADDR_W  = 14
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [2*COORD_W-1:0]   size_string_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [COORD_W-1:0]     out_x_o,
    output logic [COORD_W-1:0]     out_y_o,
    output logic [ADDR_W-1:0]      out_addr_o,
    output logic                   out_last_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StScan = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [COORD_W-1:0] CoordOne = COORD_W'(1);

    logic [1:0]         state_q, state_d;
    logic [COORD_W-1:0] size_x_q, size_x_d;
    logic [COORD_W-1:0] size_y_q, size_y_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               last_q, last_d;

    logic [COORD_W-1:0] in_size_x, in_size_y;
    logic [COORD_W-1:0] x_max, y_max;
    logic               x_at_end;

    assign in_size_x = size_string_i[COORD_W-1:0];
    assign in_size_y = size_string_i[2*COORD_W-1:COORD_W];
    // Only meaningful in StScan, where both latched sizes are known to be nonzero.
    assign x_max     = size_x_q - CoordOne;
    assign y_max     = size_y_q - CoordOne;
    assign x_at_end  = (x_q == x_max);

    always_comb begin
        state_d  = state_q;
        size_x_d = size_x_q;
        size_y_d = size_y_q;
        x_d      = x_q;
        y_d      = y_q;
        addr_d   = addr_q;
        last_d   = last_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    size_x_d = in_size_x;
                    size_y_d = in_size_y;
                    if (in_size_x != '0 && in_size_y != '0) begin
                        state_d = StScan;
                        x_d     = '0;
                        y_d     = '0;
                        addr_d  = '0;
                        last_d  = (in_size_x == CoordOne) && (in_size_y == CoordOne);
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StScan: begin
                if (out_ready_i) begin
                    if (last_q) begin
                        state_d = StDone;
                    end else begin
                        // Row-major order keeps the linear address contiguous.
                        addr_d = addr_q + ADDR_W'(1);
                        if (x_at_end) begin
                            x_d    = '0;
                            y_d    = y_q + CoordOne;
                            last_d = (x_max == '0) && ((y_q + CoordOne) == y_max);
                        end else begin
                            x_d    = x_q + CoordOne;
                            last_d = ((x_q + CoordOne) == x_max) && (y_q == y_max);
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            size_x_q <= '0;
            size_y_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            size_x_q <= size_x_d;
            size_y_q <= size_y_d;
            x_q      <= x_d;
            y_q      <= y_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign out_valid_o = (state_q == StScan);
    assign out_x_o     = x_q;
    assign out_y_o     = y_q;
    assign out_addr_o  = addr_q;
    assign out_last_o  = last_q;

endmodule

// File: tb/tb_grid_scan_addr_gen.sv
// Scoreboard bench for grid_scan_addr_gen: expected beats are queued at start and popped on each
// accepted beat; stalled beats must hold their values.
module tb_grid_scan_addr_gen;

    localparam int CW = 7;
    localparam int AW = 14;

    typedef logic [2*CW+AW:0] beat_t;  // {x, y, addr, last}

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2*CW-1:0] size_string;
    logic          busy, done, out_valid, out_ready, out_last;
    logic [CW-1:0] out_x, out_y;
    logic [AW-1:0] out_addr;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    ready_mode = 0;  // 0: always ready, 1: 1,0,0,1 pattern, 2: never ready
    int    cyc = 0;
    int    lat;

    logic  stall_pend = 1'b0;
    beat_t stall_val;

    grid_scan_addr_gen #(
        .COORD_W(CW),
        .ADDR_W (AW)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .size_string_i(size_string),
        .busy_o       (busy),
        .done_o       (done),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_x_o      (out_x),
        .out_y_o      (out_y),
        .out_addr_o   (out_addr),
        .out_last_o   (out_last)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic beat_t mk_beat(input int x, input int y, input int a, input int l);
        return {CW'(x), CW'(y), AW'(a), 1'(l)};
    endfunction

    task automatic push_scan(input int sx, input int sy);
        for (int yy = 0; yy < sy; yy++) begin
            for (int xx = 0; xx < sx; xx++) begin
                exp_q.push_back(mk_beat(xx, yy, yy * sx + xx,
                                        int'((xx == sx - 1) && (yy == sy - 1))));
            end
        end
    endtask

    task automatic do_start(input int sx, input int sy);
        @(posedge clk);
        #1;
        start       = 1'b1;
        size_string = {CW'(sy), CW'(sx)};
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts negedges after the start-sampling edge until done is seen.
    task automatic wait_done(input int max_cyc, output int n);
        logic found;
        found = 1'b0;
        n     = 0;
        while (!found && n < max_cyc) begin
            @(negedge clk);
            n++;
            if (done) found = 1'b1;
        end
        check_eq("done_seen", 32'(found), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_xyal"}, 32'({out_x, out_y, out_addr, out_last}), 32'd0);
    endtask

    always begin
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        beat_t cur, e;
        cur = {out_x, out_y, out_addr, out_last};
        if (rst) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check_eq("hold_valid", 32'(out_valid), 32'd1);
                check_eq("hold_beat", 32'(cur), 32'(stall_val));
            end
            stall_pend = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    check_eq("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("beat", 32'(cur), 32'(e));
                    end
                end else begin
                    stall_pend = 1'b1;
                    stall_val  = cur;
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        size_string = '0;
        out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: 3x2 at full rate
        push_scan(3, 2);
        do_start(3, 2);
        wait_done(50, lat);
        check_eq("t1_latency", 32'(lat), 32'd7);
        check_eq("t1_busy_in_done", 32'(busy), 32'd1);
        check_eq("t1_valid_in_done", 32'(out_valid), 32'd0);
        check_eq("t1_q_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check_eq("t1_done_pulse", 32'(done), 32'd0);
        check_eq("t1_busy_after", 32'(busy), 32'd0);

        // T2: 2x2 with backpressure
        ready_mode = 1;
        push_scan(2, 2);
        do_start(2, 2);
        wait_done(100, lat);
        check_eq("t2_q_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check_eq("t2_done_pulse", 32'(done), 32'd0);
        ready_mode = 0;

        // T3: zero sizes emit no beats
        do_start(0, 5);
        wait_done(10, lat);
        check_eq("t3a_latency", 32'(lat), 32'd1);
        do_start(4, 0);
        wait_done(10, lat);
        check_eq("t3b_latency", 32'(lat), 32'd1);
        @(negedge clk);
        check_eq("t3_busy_after", 32'(busy), 32'd0);

        // T4: maximum grid
        push_scan(127, 127);
        do_start(127, 127);
        wait_done(20000, lat);
        check_eq("t4_latency", 32'(lat), 32'd16130);
        check_eq("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // T5: single cell
        push_scan(1, 1);
        do_start(1, 1);
        wait_done(10, lat);
        check_eq("t5_latency", 32'(lat), 32'd2);
        check_eq("t5_q_empty", 32'(exp_q.size()), 32'd0);

        // T6: reset mid-scan after 7 beats
        push_scan(5, 5);
        do_start(5, 5);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("t6_beats_before_rst", 32'(exp_q.size()), 32'd18);
        exp_q.delete();
        @(negedge clk);
        check_idle("t6_after_rst");

        // rst and start together: reset wins
        @(posedge clk);
        #1;
        rst         = 1'b1;
        start       = 1'b1;
        size_string = {CW'(3), CW'(3)};
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle("t6_rst_start");

        // fresh 2x1 scan; a start while busy must be ignored
        ready_mode = 2;
        push_scan(2, 1);
        do_start(2, 1);
        repeat (2) @(posedge clk);
        #1;
        start       = 1'b1;
        size_string = {CW'(3), CW'(3)};
        @(posedge clk);
        #1;
        start      = 1'b0;
        ready_mode = 0;
        wait_done(50, lat);
        check_eq("t6_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("t6_no_restart_busy", 32'(busy), 32'd0);
        check_eq("t6_no_restart_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
